alu_mul_seq: RTL and testbench
==============================

# alu_mul_seq

Multi-cycle unsigned multiplier sequencer that borrows the shared core ALU. It computes a dw×dw→2·dw product by shift-and-add, issuing one ALU operation per clock (ADD, then ROR through carry twice per multiplier bit). It sits between the CPU control path and the ALU instance: when idle it passes the CPU's ALU controls straight through; while busy it owns the ALU and stalls the CPU.

## Interface
- dw, 16: data width (8 for 6502, 16 for 65Org16); must match the ALU instance.

- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  request; accepted when start=1 and busy=0
- a  in  dw  multiplicand, sampled at acceptance
- b  in  dw  multiplier, sampled at acceptance
- addend  in  dw  accumulate term, sampled at acceptance (only with MUL_MAC_EN)
- busy  out  1  sequencer owns the ALU; CPU must hold off
- done  out  1  one-cycle pulse: product valid
- product  out  2·dw  {PH,PL}
- cpu_op/cpu_right/cpu_AI/cpu_BI/cpu_CI/cpu_RDY  in  4/1/dw/dw/1/1  CPU's ALU controls
- alu_op/alu_right/alu_AI/alu_BI/alu_CI/alu_RDY  out  4/1/dw/dw/1/1  to ALU
- alu_OUT  in  dw  registered ALU result
- alu_CO  in  1  registered ALU carry

## Operation
- Registers: PH, PL (dw each), M (dw), cnt (counts dw..1), state ∈ {IDLE, ADD, RORH, RORL, FIN}.
- ALU mux: state=IDLE → alu_* = cpu_* (combinational pass-through). Otherwise alu_RDY=1 and sequencer drives the controls below; cpu_* ignored.
- IDLE: on accept, M←a, PL←b, PH←0, cnt←dw, busy←1, → ADD.
- ADD: op=0011, right=0, AI=PH, BI = bit ? M : 0, CI=0. bit = PL[0] on first iteration, else alu_OUT[0]. If not first iteration, PL←alu_OUT. → RORH.
- RORH: op=1111, right=1, AI=alu_OUT, CI=alu_CO (ALU yields OUT={CI,AI>>1}, CO=AI[0]). → RORL.
- RORL: op=1111, right=1, AI=PL, CI=alu_CO; PH←alu_OUT; cnt←cnt−1. → ADD if cnt≠1, else → FIN.
- FIN: drives ALU idle values (op=1111, right=0, AI=BI=0, CI=0); PL←alu_OUT; busy←0; done←1; → IDLE.
- done is cleared on the next edge unconditionally.
- product is {PH,PL}: changes while busy; stable from done until the next acceptance.
- start while busy=1: ignored, not queued. start in the done cycle: accepted (busy=0).
- ALU flags/OUT after an operation are sequencer garbage; the CPU must not consume ALU results across a busy window.
- Arithmetic: max PH+M = 2·(2^dw−1) fits dw+1 bits, so carry is captured exactly; no overflow possible.
- Reset (any state, including mid-operation): state=IDLE, busy=0, done=0, PH=PL=M=0, cnt=0; ALU reverts to pass-through immediately.

## Timing
- Acceptance edge = edge 0. Iteration k (1..dw) occupies cycles 3k−2..3k. FIN in cycle 3·dw+1.
- done=1 and product valid after edge 3·dw+1: 25 clocks for dw=8, 49 for dw=16. Fixed, data-independent.
- busy rises after edge 0, falls after edge 3·dw+1 (same edge done rises).
- Pass-through path is purely combinational; zero added latency for the CPU when idle.
- Sequencer relies on ALU latency of exactly one clock (alu_RDY forced 1).

## Configuration
- MUL_MAC_EN defined: addend port present; at acceptance PH←addend, giving product = a·b + addend (cannot overflow 2·dw bits). Latency unchanged.
- MUL_MAC_EN undefined: addend port absent; PH←0; product = a·b.

## Test plan
- dw=8, a=0x0D, b=0x0B → done after 25 clocks, product=0x008F; busy high exactly 25 cycles.
- dw=8, a=0xFF, b=0xFF → product=0xFE01; with MUL_MAC_EN and addend=0xFF → 0xFF00.
- dw=16, a=0xFFFF, b=0x0000 → product=0x00000000 after 49 clocks; a=0x1234, b=0x5678 → 0x06260060.
- Idle pass-through: vary cpu_op/AI/BI/CI/right/RDY with start=0 → alu_* equals cpu_* each cycle; during busy, alu_RDY=1 regardless of cpu_RDY=0.
- start pulsed at cycle 5 of a running op → ignored, single done; start held high through done cycle → back-to-back op accepted, second done 25 clocks later.
- reset_n low at cycle 10 of an op → busy=0, done=0, product=0 immediately (async); no done follows; new start after release completes normally.

Source files
------------

// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared ALU, one ALU op per clock.
// Define MUL_MAC_EN to add the addend port (product = a*b + addend).
module alu_mul_seq #(
    parameter int dw = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [dw-1:0]     a,
    input  logic [dw-1:0]     b,
`ifdef MUL_MAC_EN
    input  logic [dw-1:0]     addend,
`endif
    output logic              busy,
    output logic              done,
    output logic [2*dw-1:0]   product,
    input  logic [3:0]        cpu_op,
    input  logic              cpu_right,
    input  logic [dw-1:0]     cpu_AI,
    input  logic [dw-1:0]     cpu_BI,
    input  logic              cpu_CI,
    input  logic              cpu_RDY,
    output logic [3:0]        alu_op,
    output logic              alu_right,
    output logic [dw-1:0]     alu_AI,
    output logic [dw-1:0]     alu_BI,
    output logic              alu_CI,
    output logic              alu_RDY,
    input  logic [dw-1:0]     alu_OUT,
    input  logic              alu_CO
);

    localparam int CW = $clog2(dw + 1);

    typedef enum logic [2:0] {
        IDLE,
        ADD,
        RORH,
        RORL,
        FIN
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [dw-1:0]   ph;
    logic [dw-1:0]   pl;
    logic [dw-1:0]   m;
    logic [CW-1:0]   cnt;
    logic            first_iter;
    logic            mul_bit;
    logic [dw-1:0]   ph_init;

`ifdef MUL_MAC_EN
    assign ph_init = addend;
`else
    assign ph_init = '0;
`endif

    // On the first pass PL is still the raw multiplier; afterwards the rotated PL sits in alu_OUT
    assign first_iter = (cnt == CW'(dw));
    assign mul_bit    = first_iter ? pl[0] : alu_OUT[0];
    assign busy       = (state != IDLE);
    assign product    = {ph, pl};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            done  <= 1'b0;
            ph    <= '0;
            pl    <= '0;
            m     <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        m   <= a;
                        pl  <= b;
                        ph  <= ph_init;
                        cnt <= CW'(dw);
                    end
                end
                ADD: begin
                    if (!first_iter) begin
                        pl <= alu_OUT;
                    end
                end
                RORL: begin
                    ph  <= alu_OUT;
                    cnt <= cnt - CW'(1);
                end
                FIN: begin
                    pl   <= alu_OUT;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Idle: CPU controls pass straight through; otherwise the sequencer owns the ALU
    always_comb begin
        state_nxt = state;
        alu_op    = 4'b1111;
        alu_right = 1'b0;
        alu_AI    = '0;
        alu_BI    = '0;
        alu_CI    = 1'b0;
        alu_RDY   = 1'b1;
        case (state)
            IDLE: begin
                alu_op    = cpu_op;
                alu_right = cpu_right;
                alu_AI    = cpu_AI;
                alu_BI    = cpu_BI;
                alu_CI    = cpu_CI;
                alu_RDY   = cpu_RDY;
                if (start) begin
                    state_nxt = ADD;
                end
            end
            ADD: begin
                alu_op    = 4'b0011;
                alu_AI    = ph;
                alu_BI    = mul_bit ? m : '0;
                state_nxt = RORH;
            end
            RORH: begin
                alu_right = 1'b1;
                alu_AI    = alu_OUT;
                alu_CI    = alu_CO;
                state_nxt = RORL;
            end
            RORL: begin
                alu_right = 1'b1;
                alu_AI    = pl;
                alu_CI    = alu_CO;
                state_nxt = (cnt != CW'(1)) ? ADD : FIN;
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_mul_seq.sv
// Scoreboard bench for alu_mul_seq: dw=8 and dw=16 instances, each driving a behavioural ALU model.
module tb_alu_mul_seq;

    typedef struct {
        logic [31:0] prod;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;
    exp_t q8[$];
    exp_t q16[$];

    // dw = 8 instance signals
    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] product8;
    logic [3:0]  cpu_op8 = '0;
    logic        cpu_right8 = 1'b0, cpu_CI8 = 1'b0, cpu_RDY8 = 1'b1;
    logic [7:0]  cpu_AI8 = '0, cpu_BI8 = '0;
    logic [3:0]  alu_op8;
    logic        alu_right8, alu_CI8, alu_RDY8;
    logic [7:0]  alu_AI8, alu_BI8;
    logic [7:0]  alu_OUT8 = '0;
    logic        alu_CO8 = 1'b0;
    logic [7:0]  lg8, tbi8;

    // dw = 16 instance signals
    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        busy16, done16;
    logic [31:0] product16;
    logic [3:0]  alu_op16;
    logic        alu_right16, alu_CI16, alu_RDY16;
    logic [15:0] alu_AI16, alu_BI16;
    logic [15:0] alu_OUT16 = '0;
    logic        alu_CO16 = 1'b0;
    logic [15:0] lg16, tbi16;

`ifdef MUL_MAC_EN
    logic [7:0]  addend8 = '0;
    logic [15:0] addend16 = '0;
    localparam logic [31:0] FF_EXP = 32'h0000FF00;
`else
    localparam logic [31:0] FF_EXP = 32'h0000FE01;
`endif

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    alu_mul_seq #(.dw(8)) dut8 (
        .clk(clk), .reset_n(reset_n), .start(start8), .a(a8), .b(b8),
`ifdef MUL_MAC_EN
        .addend(addend8),
`endif
        .busy(busy8), .done(done8), .product(product8),
        .cpu_op(cpu_op8), .cpu_right(cpu_right8), .cpu_AI(cpu_AI8), .cpu_BI(cpu_BI8),
        .cpu_CI(cpu_CI8), .cpu_RDY(cpu_RDY8),
        .alu_op(alu_op8), .alu_right(alu_right8), .alu_AI(alu_AI8), .alu_BI(alu_BI8),
        .alu_CI(alu_CI8), .alu_RDY(alu_RDY8), .alu_OUT(alu_OUT8), .alu_CO(alu_CO8)
    );

    alu_mul_seq #(.dw(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .start(start16), .a(a16), .b(b16),
`ifdef MUL_MAC_EN
        .addend(addend16),
`endif
        .busy(busy16), .done(done16), .product(product16),
        .cpu_op(4'b0000), .cpu_right(1'b0), .cpu_AI(16'h0000), .cpu_BI(16'h0000),
        .cpu_CI(1'b0), .cpu_RDY(1'b0),
        .alu_op(alu_op16), .alu_right(alu_right16), .alu_AI(alu_AI16), .alu_BI(alu_BI16),
        .alu_CI(alu_CI16), .alu_RDY(alu_RDY16), .alu_OUT(alu_OUT16), .alu_CO(alu_CO16)
    );

    // Behavioural 6502-style ALU: logic stage by op[1:0], B operand by op[3:2], registered result
    always_comb begin
        lg8 = alu_AI8;
        case (alu_op8[1:0])
            2'b00: lg8 = alu_AI8 | alu_BI8;
            2'b01: lg8 = alu_AI8 & alu_BI8;
            2'b10: lg8 = alu_AI8 ^ alu_BI8;
            default: lg8 = alu_AI8;
        endcase
        tbi8 = '0;
        case (alu_op8[3:2])
            2'b00: tbi8 = alu_BI8;
            2'b01: tbi8 = ~alu_BI8;
            2'b10: tbi8 = lg8;
            default: tbi8 = '0;
        endcase
        lg16 = alu_AI16;
        case (alu_op16[1:0])
            2'b00: lg16 = alu_AI16 | alu_BI16;
            2'b01: lg16 = alu_AI16 & alu_BI16;
            2'b10: lg16 = alu_AI16 ^ alu_BI16;
            default: lg16 = alu_AI16;
        endcase
        tbi16 = '0;
        case (alu_op16[3:2])
            2'b00: tbi16 = alu_BI16;
            2'b01: tbi16 = ~alu_BI16;
            2'b10: tbi16 = lg16;
            default: tbi16 = '0;
        endcase
    end

    always @(posedge clk) begin
        if (alu_RDY8) begin
            if (alu_right8) begin
                alu_OUT8 <= {alu_CI8, lg8[7:1]};
                alu_CO8  <= lg8[0];
            end else begin
                {alu_CO8, alu_OUT8} <= {1'b0, lg8} + {1'b0, tbi8} + {8'h00, alu_CI8};
            end
        end
        if (alu_RDY16) begin
            if (alu_right16) begin
                alu_OUT16 <= {alu_CI16, lg16[15:1]};
                alu_CO16  <= lg16[0];
            end else begin
                {alu_CO16, alu_OUT16} <= {1'b0, lg16} + {1'b0, tbi16} + {16'h0000, alu_CI16};
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Monitors: every done pulse must match the oldest outstanding expectation, value and cycle
    always @(negedge clk) begin
        if (reset_n && done8) begin
            if (q8.size() == 0) begin
                failNow("unexpected_done8");
            end else begin
                exp_t e;
                e = q8.pop_front();
                checkOutput("product8", {16'h0000, product8}, e.prod);
                checkOutput("done_cycle8", cyc, e.due);
            end
        end
        if (reset_n && done16) begin
            if (q16.size() == 0) begin
                failNow("unexpected_done16");
            end else begin
                exp_t e;
                e = q16.pop_front();
                checkOutput("product16", product16, e.prod);
                checkOutput("done_cycle16", cyc, e.due);
            end
        end
    end

    task automatic waitIdle8();
        int n = 0;
        @(negedge clk);
        while (busy8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (busy8) failNow("idle_timeout8");
    endtask

    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic [31:0] exp);
        exp_t e;
        waitIdle8();
        a8     = av;
        b8     = bv;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        e.prod = exp;
        e.due  = cyc + 25;
        q8.push_back(e);
        start8 = 1'b0;
        checkOutput("busy_after_accept8", {31'd0, busy8}, 32'd1);
    endtask

    task automatic applyStimulus16(input logic [15:0] av, input logic [15:0] bv, input logic [31:0] exp);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (busy16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        a16     = av;
        b16     = bv;
        start16 = 1'b1;
        @(posedge clk);
        #1;
        e.prod = exp;
        e.due  = cyc + 49;
        q16.push_back(e);
        start16 = 1'b0;
    endtask

    task automatic waitDrain();
        int n = 0;
        while ((q8.size() != 0 || q16.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (q8.size() != 0 || q16.size() != 0) begin
            failNow("drain_timeout");
            q8.delete();
            q16.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    logic [17:0] pass_vec [4] = '{18'h3_0000, 18'h2_5A3C, 18'h0_FF01, 18'h1_8081};

    initial begin
        int n;
        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_busy8", {31'd0, busy8}, 32'd0);
        checkOutput("reset_done8", {31'd0, done8}, 32'd0);
        checkOutput("reset_product8", {16'h0000, product8}, 32'd0);
        checkOutput("reset_product16", product16, 32'd0);
        reset_n = 1'b1;

        // Idle pass-through with assorted CPU controls
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            cpu_op8    = pass_vec[i][17:14] ^ 4'(i * 5);
            cpu_right8 = pass_vec[i][16];
            cpu_AI8    = pass_vec[i][15:8];
            cpu_BI8    = pass_vec[i][7:0];
            cpu_CI8    = pass_vec[i][0];
            cpu_RDY8   = pass_vec[i][1];
            #1;
            checkOutput("passthru8",
                {8'h00, alu_op8, alu_right8, alu_AI8, alu_BI8, alu_CI8, alu_RDY8},
                {8'h00, cpu_op8, cpu_right8, cpu_AI8, cpu_BI8, cpu_CI8, cpu_RDY8});
        end

        // Basic product with busy-window length and RDY override
        applyStimulus(8'h0D, 8'h0B, 32'h008F);
        cpu_RDY8 = 1'b0;
        @(negedge clk);
        checkOutput("busy_rdy_forced8", {31'd0, alu_RDY8}, 32'd1);
        n = 0;
        while (busy8 && n < 100) begin
            n++;
            @(negedge clk);
        end
        checkOutput("busy_cycles8", n, 32'd25);
        cpu_RDY8 = 1'b1;
        waitDrain();

        // Directed products
`ifdef MUL_MAC_EN
        addend8 = 8'hFF;
`endif
        applyStimulus(8'hFF, 8'hFF, FF_EXP);
        waitIdle8();
`ifdef MUL_MAC_EN
        addend8 = 8'h00;
`endif
        applyStimulus(8'h00, 8'h37, 32'h0000);
        applyStimulus(8'h80, 8'h02, 32'h0100);
        applyStimulus(8'h01, 8'hFF, 32'h00FF);
        applyStimulus16(16'hFFFF, 16'h0000, 32'h00000000);
        applyStimulus16(16'h1234, 16'h5678, 32'h06260060);
        waitDrain();

        // Start pulsed mid-operation is ignored
        applyStimulus(8'hA5, 8'h3C, 32'h26AC);
        repeat (4) @(posedge clk);
        #1;
        a8 = 8'hFF;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        waitDrain();
        repeat (30) @(negedge clk);

        // Start held through done: second op accepted in the done cycle
        applyStimulus(8'h12, 8'h34, 32'h03A8);
        start8 = 1'b1;
        n = 0;
        while (!done8 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done8) failNow("b2b_done_timeout8");
        a8 = 8'h07;
        b8 = 8'h09;
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.prod = 32'h003F;
            e.due  = cyc + 25;
            q8.push_back(e);
        end
        start8 = 1'b0;
        checkOutput("b2b_busy8", {31'd0, busy8}, 32'd1);
        waitDrain();

        // Asynchronous reset mid-operation
        applyStimulus(8'h55, 8'h55, 32'h1C39);
        repeat (9) @(posedge clk);
        @(negedge clk);
        cpu_RDY8 = 1'b0;
        cpu_op8  = 4'b0101;
        reset_n  = 1'b0;
        #1;
        q8.delete();
        checkOutput("midreset_busy8", {31'd0, busy8}, 32'd0);
        checkOutput("midreset_done8", {31'd0, done8}, 32'd0);
        checkOutput("midreset_product8", {16'h0000, product8}, 32'd0);
        checkOutput("midreset_passthru8", {27'd0, alu_op8, alu_RDY8}, {27'd0, 4'b0101, 1'b0});
        @(negedge clk);
        reset_n  = 1'b1;
        cpu_RDY8 = 1'b1;
        repeat (40) @(negedge clk);
        applyStimulus(8'hC8, 8'h64, 32'h4E20);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
